// File: rtl/instr_pkg.sv
// Shared definitions for the RV32I instruction encoder: micro-op classes, opcodes,
// immediate forms and encoder FSM states.
package instr_pkg;

  typedef enum logic [3:0] {
    ClsLoad   = 4'd0,
    ClsStore  = 4'd1,
    ClsRtype  = 4'd2,
    ClsBranch = 4'd3,
    ClsItype  = 4'd4,
    ClsJal    = 4'd5,
    ClsAuipc  = 4'd6,
    ClsLui    = 4'd7,
    ClsJalr   = 4'd8
  } cls_e;

  // Form codes line up with the main decoder's ImmSrc encoding.
  typedef enum logic [2:0] {
    FormI = 3'b000,
    FormS = 3'b001,
    FormB = 3'b010,
    FormJ = 3'b011,
    FormU = 3'b100,
    FormR = 3'b101
  } form_e;

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpRtype  = 7'h33;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpItype  = 7'h13;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpJalr   = 7'h67;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/imm_pack.sv
// Places an immediate into its RV32I bit positions for the given form and reports
// whether the value is representable in that form.
module imm_pack
  import instr_pkg::*;
(
  input  logic [2:0]  form_i,
  input  logic [31:0] imm_i,
  output logic [31:0] field_o,
  output logic        fits_o
);

  logic sext12, sext13, sext21;

  assign sext12 = (imm_i[31:11] == {21{imm_i[11]}});
  assign sext13 = (imm_i[31:12] == {20{imm_i[12]}});
  assign sext21 = (imm_i[31:20] == {12{imm_i[20]}});

  always_comb begin
    field_o = '0;
    fits_o  = 1'b1;
    case (form_i)
      FormI: begin
        field_o = {imm_i[11:0], 20'b0};
        fits_o  = sext12;
      end
      FormS: begin
        field_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        fits_o  = sext12;
      end
      FormB: begin
        field_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        fits_o  = sext13 && !imm_i[0];
      end
      FormJ: begin
        field_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        fits_o  = sext21 && !imm_i[0];
      end
      FormU: begin
        field_o = {imm_i[31:12], 12'b0};
        fits_o  = (imm_i[11:0] == 12'b0);
      end
      default: begin
        field_o = '0;
        fits_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs micro-ops into instruction words and writes them to
// consecutive IMEM addresses. Define ENC_RANGE_CHECK_EN to drop immediates that do not fit.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_class_i,
  input  logic [2:0]        in_funct3_i,
  input  logic              in_f7b_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [31:0]       in_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [31:0]       out_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     acc_q, acc_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         data_q, data_d;
  logic                err_q, err_d;

  logic [2:0]  form;
  logic [6:0]  opcode;
  logic        use_rd, use_f3, use_rs1, use_rs2, set_b30, legal;
  logic [31:0] field, word;
  logic        fits, drop, in_fire, out_fire;

  always_comb begin
    form    = FormR;
    opcode  = '0;
    use_rd  = 1'b0;
    use_f3  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    set_b30 = 1'b0;
    legal   = 1'b1;
    case (in_class_i)
      ClsLoad:   begin form = FormI; opcode = OpLoad;   {use_rd, use_f3, use_rs1} = '1; end
      ClsStore:  begin form = FormS; opcode = OpStore;  {use_f3, use_rs1, use_rs2} = '1; end
      ClsRtype:  begin
        form = FormR; opcode = OpRtype; {use_rd, use_f3, use_rs1, use_rs2} = '1;
        set_b30 = 1'b1;
      end
      ClsBranch: begin form = FormB; opcode = OpBranch; {use_f3, use_rs1, use_rs2} = '1; end
      ClsItype:  begin
        form = FormI; opcode = OpItype; {use_rd, use_f3, use_rs1} = '1;
        set_b30 = (in_funct3_i == 3'b101);
      end
      ClsJal:    begin form = FormJ; opcode = OpJal;    use_rd = 1'b1; end
      ClsAuipc:  begin form = FormU; opcode = OpAuipc;  use_rd = 1'b1; end
      ClsLui:    begin form = FormU; opcode = OpLui;    use_rd = 1'b1; end
      ClsJalr:   begin form = FormI; opcode = OpJalr;   {use_rd, use_rs1} = '1; end
      default:   legal = 1'b0;
    endcase
  end

  imm_pack u_imm_pack (
    .form_i  (form),
    .imm_i   (in_imm_i),
    .field_o (field),
    .fits_o  (fits)
  );

  // Register fields overlay the immediate; the shift/sub bit overrides imm bit 30.
  always_comb begin
    word       = field;
    word[6:0]  = opcode;
    if (use_rd)  word[11:7]  = in_rd_i;
    if (use_f3)  word[14:12] = in_funct3_i;
    if (use_rs1) word[19:15] = in_rs1_i;
    if (use_rs2) word[24:20] = in_rs2_i;
    if (set_b30) word[30]    = in_f7b_i;
  end

`ifdef ENC_RANGE_CHECK_EN
  assign drop = !legal || !fits;
`else
  logic unused_fits;
  assign unused_fits = fits;
  assign drop        = !legal;
`endif

  assign out_fire   = out_valid_q && out_ready_i;
  assign in_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
  assign in_fire    = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    err_d       = 1'b0;
    if (out_fire) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + 1'b1;
    end
    if (in_fire) begin
      acc_d = acc_q + 1'b1;
      if (drop) begin
        err_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        data_d      = word;
      end
    end
    case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d   = count_i;
          acc_d   = '0;
          addr_d  = ADDR_W'(BASE);
          state_d = (count_i == '0) ? StDone : StRun;
        end
      end
      StRun:   if (in_fire && (acc_d == cnt_q)) state_d = StDrain;
      // Leave as the final word is taken so done lands the cycle after that handshake.
      StDrain: if (!out_valid_d) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= ADDR_W'(BASE);
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: known-encoding table, corner-case sequences and
// randomized loads checked against an arithmetic reference model.
module tb_instr_encoder;

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  count;
  logic        in_valid;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_f7b;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_ready;

  logic        in_ready0, out_valid0, busy0, done0, err0;
  logic [7:0]  out_addr0;
  logic [31:0] out_data0;
  logic        in_ready1, out_valid1, busy1, done1, err1;
  logic [1:0]  out_addr1;
  logic [31:0] out_data1;

  always #5 clk = ~clk;

  instr_encoder dut0 (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start), .count_i (count),
    .in_valid_i (in_valid), .in_ready_o (in_ready0), .in_class_i (in_class),
    .in_funct3_i (in_funct3), .in_f7b_i (in_f7b), .in_rd_i (in_rd), .in_rs1_i (in_rs1),
    .in_rs2_i (in_rs2), .in_imm_i (in_imm), .out_valid_o (out_valid0),
    .out_ready_i (out_ready), .out_addr_o (out_addr0), .out_data_o (out_data0),
    .busy_o (busy0), .done_o (done0), .err_o (err0)
  );

  instr_encoder #(.ADDR_W(2), .BASE(3)) dut1 (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start), .count_i (count[2:0]),
    .in_valid_i (in_valid), .in_ready_o (in_ready1), .in_class_i (in_class),
    .in_funct3_i (in_funct3), .in_f7b_i (in_f7b), .in_rd_i (in_rd), .in_rs1_i (in_rs1),
    .in_rs2_i (in_rs2), .in_imm_i (in_imm), .out_valid_o (out_valid1),
    .out_ready_i (out_ready), .out_addr_o (out_addr1), .out_data_o (out_data1),
    .busy_o (busy1), .done_o (done1), .err_o (err1)
  );

  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0, start_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  int  err_cnt = 0, done_cnt = 0;
  bit  done_flag = 1'b0, rand_rdy = 1'b0;
  wr_t obs0[$], obs1[$], exp_q[$];
  vec_t tbl[8];

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

  // Observe well after the negedge drivers have settled and before the next posedge.
  always begin
    @(negedge clk);
    #2;
    if (out_valid0 && out_ready) begin
      obs0.push_back('{32'(out_addr0), out_data0});
      last_wr_cyc = cyc;
    end
    if (out_valid1 && out_ready) obs1.push_back('{32'(out_addr1), out_data1});
    if (err0) err_cnt++;
    if (done0) begin
      done_flag = 1'b1;
      done_cyc  = cyc;
      done_cnt++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout, want event", nm);
  endtask

  function automatic op_t mk(input int c, input int f3, input int f7, input int rd,
                             input int r1, input int r2, input logic [31:0] imm);
    op_t o;
    o.cls = 4'(c); o.f3 = 3'(f3); o.f7b = 1'(f7);
    o.rd = 5'(rd); o.rs1 = 5'(r1); o.rs2 = 5'(r2); o.imm = imm;
    return o;
  endfunction

  // Reference encoder built directly from the field and immediate placement rules.
  function automatic logic [31:0] ref_enc(input op_t o, output bit drop);
    logic [31:0] i, w, rd, f3, r1, r2, im_i, im_s, im_b, im_j, im_u;
    int si;
    bit fit_i, fit_b, fit_j, fit_u, fit;
    i  = o.imm;
    si = o.imm;
    rd = 32'(o.rd) << 7;
    f3 = 32'(o.f3) << 12;
    r1 = 32'(o.rs1) << 15;
    r2 = 32'(o.rs2) << 20;
    im_i = (i & 32'hFFF) << 20;
    im_s = (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
    im_b = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25)
         | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7);
    im_j = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
         | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12);
    im_u = i & 32'hFFFFF000;
    fit_i = (si >= -2048) && (si <= 2047);
    fit_b = (si >= -4096) && (si <= 4095) && (i % 2 == 0);
    fit_j = (si >= -1048576) && (si <= 1048575) && (i % 2 == 0);
    fit_u = (i & 32'hFFF) == 0;
    drop = 1'b0;
    fit  = 1'b1;
    w    = 0;
    case (int'(o.cls))
      0: begin w = 32'h03 | rd | f3 | r1 | im_i; fit = fit_i; end
      1: begin w = 32'h23 | f3 | r1 | r2 | im_s; fit = fit_i; end
      2: w = 32'h33 | rd | f3 | r1 | r2 | (32'(o.f7b) << 30);
      3: begin w = 32'h63 | f3 | r1 | r2 | im_b; fit = fit_b; end
      4: begin
        w = 32'h13 | rd | f3 | r1 | im_i;
        if (o.f3 == 3'd5) w = (w & ~32'h40000000) | (32'(o.f7b) << 30);
        fit = fit_i;
      end
      5: begin w = 32'h6F | rd | im_j; fit = fit_j; end
      6: begin w = 32'h17 | rd | im_u; fit = fit_u; end
      7: begin w = 32'h37 | rd | im_u; fit = fit_u; end
      8: begin w = 32'h67 | rd | r1 | im_i; fit = fit_i; end
      default: drop = 1'b1;
    endcase
    if (RangeEn && !fit) drop = 1'b1;
    return w;
  endfunction

  task automatic do_start(input int cnt);
    start     = 1'b1;
    count     = 9'(cnt);
    start_cyc = cyc;
    done_flag = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_op(input op_t o);
    int g = 0;
    in_class = o.cls; in_funct3 = o.f3; in_f7b = o.f7b;
    in_rd = o.rd; in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm;
    in_valid = 1'b1;
    #1;
    while (!in_ready0 && g < 500) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready0) timeout("in_ready");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done_flag && g < 2000) begin
      @(posedge clk);
      g++;
    end
    if (!done_flag) timeout("done");
    @(negedge clk);
  endtask

  task automatic check_q(input string nm, input wr_t got[$]);
    check({nm, "_n"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      check($sformatf("%s_addr%0d", nm, k), got[k].addr, exp_q[k].addr);
      check($sformatf("%s_data%0d", nm, k), got[k].data, exp_q[k].data);
    end
  endtask

  initial begin
    int e0, d0, n, nerr;
    logic [31:0] a;
    op_t ops[$];
    bit dr;
    logic [31:0] w;

    rst_n = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_funct3 = '0; in_f7b = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0;

    tbl[0] = '{mk(4, 0, 0, 1, 0, 0, 32'd5),     32'h00500093};
    tbl[1] = '{mk(0, 2, 0, 2, 1, 0, 32'd8),     32'h0080A103};
    tbl[2] = '{mk(1, 2, 0, 0, 1, 2, 32'd4),     32'h0020A223};
    tbl[3] = '{mk(3, 0, 0, 0, 1, 2, -32'sd4),   32'hFE208EE3};
    tbl[4] = '{mk(5, 0, 0, 1, 0, 0, 32'd2048),  32'h001000EF};
    tbl[5] = '{mk(7, 0, 0, 5, 0, 0, 32'h12345000), 32'h123452B7};
    tbl[6] = '{mk(2, 0, 1, 3, 1, 2, 32'd0),     32'h402081B3};
    tbl[7] = '{mk(4, 5, 1, 4, 1, 0, 32'd3),     32'h4030D213};

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready0), 0);
    check("rst_out_valid", 32'(out_valid0), 0);
    check("rst_out_addr", 32'(out_addr0), 0);
    check("rst_out_data", out_data0, 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_out_addr_b3", 32'(out_addr1), 3);
    check("rst_misc_b3", 32'({in_ready1, out_valid1, busy1, done1, err1}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two table loads of four words each; base reloads on each start.
    for (int l = 0; l < 2; l++) begin
      obs0.delete(); exp_q.delete();
      d0 = done_cnt;
      do_start(4);
      for (int k = 0; k < 4; k++) send_op(tbl[4 * l + k].op);
      wait_done();
      for (int k = 0; k < 4; k++) exp_q.push_back('{32'(k), tbl[4 * l + k].exp});
      check_q($sformatf("tbl%0d", l), obs0);
      check("done_lat", 32'(done_cyc), 32'(last_wr_cyc + 1));
      check("done_pulses", 32'(done_cnt - d0), 1);
    end

    // Narrow address counter wraps 3 -> 0 -> 1.
    obs1.delete(); exp_q.delete();
    do_start(3);
    for (int k = 0; k < 3; k++) send_op(tbl[k].op);
    wait_done();
    exp_q.push_back('{32'd3, tbl[0].exp});
    exp_q.push_back('{32'd0, tbl[1].exp});
    exp_q.push_back('{32'd1, tbl[2].exp});
    check_q("wrap", obs1);

    // Empty load finishes one cycle after start.
    obs0.delete();
    do_start(0);
    wait_done();
    check("cnt0_done_lat", 32'(done_cyc), 32'(start_cyc + 1));
    check("cnt0_writes", 32'(obs0.size()), 0);

    // Backpressure: staged word held, no new acceptance, nothing lost.
    obs0.delete(); exp_q.delete();
    do_start(2);
    send_op(tbl[0].op);
    out_ready = 1'b0;
    in_class = tbl[1].op.cls; in_funct3 = tbl[1].op.f3; in_rd = tbl[1].op.rd;
    in_rs1 = tbl[1].op.rs1; in_rs2 = tbl[1].op.rs2; in_imm = tbl[1].op.imm;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid", 32'(out_valid0), 1);
      check("bp_data", out_data0, tbl[0].exp);
      check("bp_addr", 32'(out_addr0), 0);
      check("bp_in_ready", 32'(in_ready0), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send_op(tbl[1].op);
    wait_done();
    exp_q.push_back('{32'd0, tbl[0].exp});
    exp_q.push_back('{32'd1, tbl[1].exp});
    check_q("bp", obs0);

    // addi with an immediate one past the 12-bit range.
    obs0.delete(); exp_q.delete();
    e0 = err_cnt;
    do_start(2);
    send_op(mk(4, 0, 0, 1, 0, 0, 32'd2048));
    send_op(tbl[1].op);
    wait_done();
`ifdef ENC_RANGE_CHECK_EN
    exp_q.push_back('{32'd0, tbl[1].exp});
    check("range_err", 32'(err_cnt - e0), 1);
`else
    exp_q.push_back('{32'd0, 32'h80000093});
    exp_q.push_back('{32'd1, tbl[1].exp});
    check("range_err", 32'(err_cnt - e0), 0);
`endif
    check_q("range", obs0);

    // Illegal class, then reset in the middle of the load.
    obs0.delete();
    do_start(3);
    send_op(mk(12, 0, 0, 1, 1, 1, 32'd0));
    #1;
    check("ill_err_pulse", 32'(err0), 1);
    check("ill_no_valid", 32'(out_valid0), 0);
    @(negedge clk);
    #1;
    check("ill_err_end", 32'(err0), 0);
    check("ill_busy", 32'(busy0), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy0), 0);
    check("mrst_out_valid", 32'(out_valid0), 0);
    check("mrst_out_addr", 32'(out_addr0), 0);
    check("mrst_out_addr_b3", 32'(out_addr1), 3);
    check("mrst_in_ready", 32'(in_ready0), 0);
    check("ill_writes", 32'(obs0.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized loads with random backpressure against the reference model.
    for (int l = 0; l < 4; l++) begin
      obs0.delete(); exp_q.delete(); ops.delete();
      n = $urandom_range(1, 24);
      a = 0;
      nerr = 0;
      for (int k = 0; k < n; k++) begin
        op_t o;
        o.cls = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        o.f3 = 3'($urandom); o.f7b = 1'($urandom);
        o.rd = 5'($urandom); o.rs1 = 5'($urandom); o.rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
          0: o.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          1: o.imm = $urandom;
          2: o.imm = $urandom & 32'hFFFFF000;
          default: o.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'h1;
        endcase
        ops.push_back(o);
        w = ref_enc(o, dr);
        if (dr) nerr++;
        else begin
          exp_q.push_back('{a, w});
          a = (a + 1) % 256;
        end
      end
      e0 = err_cnt;
      rand_rdy = 1'b1;
      do_start(n);
      foreach (ops[k]) send_op(ops[k]);
      wait_done();
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      check_q($sformatf("rnd%0d", l), obs0);
      check("rnd_err", 32'(err_cnt - e0), 32'(nerr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
